// File: rtl/xinlv_top.sv
// Heart-rate front end: 8N1 UART receiver, "BPMdd" frame parser and BCD-to-binary stage.
// xinlv holds the rate from the last complete frame; truncated or malformed frames leave it alone.
module xinlv_top #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_rx,
    output logic [7:0] xinlv
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [7:0] ChB = 8'h42;
    localparam logic [7:0] ChP = 8'h50;
    localparam logic [7:0] ChM = 8'h4D;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {PsWaitB, PsGotB, PsGotP, PsGotM, PsGotT} ps_state_e;

    // Input synchroniser plus one extra stage for falling-edge detection.
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_valid_q, rx_valid_d;
    logic [7:0]      rx_byte;

    ps_state_e  ps_state_q, ps_state_d;
    logic [3:0] tens_q, tens_d;
    logic [7:0] xinlv_q, xinlv_d;

    logic       is_digit;
    logic [3:0] digit;
    logic [6:0] tens_x10;
    logic [6:0] bcd_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= data_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= RxIdle;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_valid_d = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (clk_cnt_q == HalfLast) begin
                    clk_cnt_d  = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            RxData: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            RxStop: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    // A low stop bit drops the byte; the edge detector then waits for the line
                    // to return high before another start bit can be seen.
                    rx_valid_d = rx_sync_q;
                    rx_state_d = RxIdle;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    assign rx_byte  = shift_q;
    assign is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    assign digit    = rx_byte[3:0];
    assign tens_x10 = {tens_q, 3'b000} + {2'b00, tens_q, 1'b0};
    assign bcd_sum  = tens_x10 + {3'b000, digit};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ps_state_q <= PsWaitB;
            tens_q     <= '0;
            xinlv_q    <= '0;
        end else begin
            ps_state_q <= ps_state_d;
            tens_q     <= tens_d;
            xinlv_q    <= xinlv_d;
        end
    end

    always_comb begin
        ps_state_d = ps_state_q;
        tens_d     = tens_q;
        xinlv_d    = xinlv_q;
        if (rx_valid_q) begin
            // Mismatch fallback; a stray 'B' restarts the frame immediately.
            ps_state_d = (rx_byte == ChB) ? PsGotB : PsWaitB;
            unique case (ps_state_q)
                PsGotB: begin
                    if (rx_byte == ChP) ps_state_d = PsGotP;
                end
                PsGotP: begin
                    if (rx_byte == ChM) ps_state_d = PsGotM;
                end
                PsGotM: begin
                    if (is_digit) begin
                        tens_d     = digit;
                        ps_state_d = PsGotT;
                    end
                end
                PsGotT: begin
                    if (is_digit) begin
                        xinlv_d    = {1'b0, bcd_sum};
                        ps_state_d = PsWaitB;
                    end
                end
                default: ;
            endcase
        end
    end

    assign xinlv = xinlv_q;

endmodule

// File: tb/tb_xinlv_top.sv
// Directed bench for xinlv_top: serialises ASCII frames onto data_rx and checks the decoded rate.
// Bit period is shortened to 16 clocks to keep the run short.
module tb_xinlv_top;

    localparam int unsigned Cpb = 16;
    localparam int unsigned Bit = Cpb * 20;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       data_rx = 1'b1;
    logic [7:0] xinlv;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #10 clk = ~clk;

    xinlv_top #(
        .CLK_FREQ    (Cpb * 9600),
        .BAUD        (9600),
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_rx(data_rx),
        .xinlv  (xinlv)
    );

    task automatic check(input string tag, input logic [7:0] exp);
        vectors++;
        assert (xinlv === exp) else begin
            miscompares++;
            $error("FAIL %s: xinlv=%0d (0x%02h) expected %0d (0x%02h)", tag, xinlv, xinlv,
                   exp, exp);
        end
    endtask

    task automatic send_head(input logic [7:0] b);
        data_rx = 1'b0;
        #(Bit);
        for (int i = 0; i < 8; i++) begin
            data_rx = b[i];
            #(Bit);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_head(b);
        data_rx = 1'b1;
        #(Bit);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    initial begin
        // Reset for one clock edge, then idle high one bit time.
        #20;
        check("reset", 8'd0);
        rst_n = 1'b1;
        #(Bit);

        // First frame; the rate must not appear before the last stop bit is sampled.
        send_str("BPM6");
        send_head("9");
        data_rx = 1'b1;
        #(Bit / 4);
        check("before_2nd_digit", 8'd0);
        #(Bit - Bit / 4);
        check("bpm69", 8'd69);

        send_str("BPM58");
        check("bpm58", 8'd58);
        send_str("BPM87");
        check("bpm87", 8'd87);
        send_str("BPM");
        check("truncated", 8'd87);

        send_str("BXPM12");
        check("bxpm12", 8'd87);
        send_str("BPM7A");
        check("bpm7a", 8'd87);
        send_str("BBPM42");
        check("bbpm42", 8'd42);

        // Short low glitch mid-frame must not inject a byte.
        send_str("BPM");
        data_rx = 1'b0;
        #100;
        data_rx = 1'b1;
        #(Bit);
        send_str("55");
        check("glitch", 8'd55);

        // 'B' with a low stop bit is dropped, so "PM12" alone must not update.
        send_head(8'h42);
        data_rx = 1'b0;
        #(Bit);
        data_rx = 1'b1;
        #(Bit);
        send_str("PM12");
        check("framing_err", 8'd55);

        // Reset in the middle of the second digit.
        send_str("BPM6");
        data_rx = 1'b0;
        #(Bit);
        data_rx = 1'b1;
        #(Bit);
        data_rx = 1'b0;
        #(Bit);
        data_rx = 1'b0;
        #(Bit / 2);
        rst_n   = 1'b0;
        data_rx = 1'b1;
        #40;
        check("reset_mid", 8'd0);
        rst_n = 1'b1;
        #(2 * Bit);
        send_str("BPM33");
        check("bpm33", 8'd33);

        send_str("BPM00");
        check("bpm00", 8'd0);
        send_str("BPM99");
        check("bpm99", 8'd99);

        vectors++;
        assert (xinlv[7] === 1'b0) else begin
            miscompares++;
            $error("FAIL msb: xinlv[7]=%b expected 0", xinlv[7]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
